// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle control unit.
// Covers the state enum, opcodes, ALU/PC mux encodings and the control output bundle.
package mc_pkg;

    typedef enum logic [3:0] {
        StInit,
        StFetch,
        StDecode,
        StMemAdr,
        StMemRd,
        StMemWb,
        StMemWr,
        StExec,
        StRwb,
        StBranch,
        StJump,
        StHalt,
        StTrap
    } state_e;

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_LW   = 4'b0001;
    localparam logic [3:0] OP_SW   = 4'b0010;
    localparam logic [3:0] OP_BEQ  = 4'b0011;
    localparam logic [3:0] OP_J    = 4'b0100;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_ONE   = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memtoReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
        logic       halted;
        logic       trap;
    } ctrl_t;

    // States that wait on mem_ready and are therefore covered by the watchdog.
    function automatic logic isWaitState(state_e s);
        return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational output decoder: state (plus mem_ready for the fetch strobes) to control bundle.
module mc_ctrl_decode
    import mc_pkg::*;
(
    input  state_e state,
    input  logic   memReady,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            StFetch: begin
                ctrl.memRead  = 1'b1;
                ctrl.iorD     = 1'b0;
                ctrl.aluSrcA  = 1'b0;
                ctrl.aluSrcB  = SRCB_ONE;
                ctrl.aluOp    = ALUOP_ADD;
                ctrl.pcSource = PCSRC_ALU;
                ctrl.irWrite  = memReady;
                ctrl.pcWrite  = memReady;
            end
            StDecode: begin
                ctrl.aluSrcA = 1'b0;
                ctrl.aluSrcB = SRCB_IMMSH;
                ctrl.aluOp   = ALUOP_ADD;
            end
            StMemAdr: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = ALUOP_ADD;
            end
            StMemRd: begin
                ctrl.memRead = 1'b1;
                ctrl.iorD    = 1'b1;
            end
            StMemWb: begin
                ctrl.regWrite = 1'b1;
                ctrl.memtoReg = 1'b1;
                ctrl.regDst   = 1'b0;
            end
            StMemWr: begin
                ctrl.memWrite = 1'b1;
                ctrl.iorD     = 1'b1;
            end
            StExec: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_REGB;
                ctrl.aluOp   = ALUOP_RTYPE;
            end
            StRwb: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = 1'b1;
                ctrl.memtoReg = 1'b0;
            end
            StBranch: begin
                ctrl.aluSrcA     = 1'b1;
                ctrl.aluSrcB     = SRCB_REGB;
                ctrl.aluOp       = ALUOP_SUB;
                ctrl.pcWriteCond = 1'b1;
                ctrl.pcSource    = PCSRC_ALUOUT;
            end
            StJump: begin
                ctrl.pcWrite  = 1'b1;
                ctrl.pcSource = PCSRC_JUMP;
            end
            StHalt:  ctrl.halted = 1'b1;
            StTrap:  ctrl.trap   = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle processor control unit: state register, next-state sequencing and memory watchdog.
// Output decoding lives in mc_ctrl_decode.
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int unsigned OPW     = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] Opcode,
    input  logic           Zero,
    input  logic           mem_ready,
    output logic           PCWrite,
    output logic           PCWriteCond,
    output logic           IorD,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           IRWrite,
    output logic           MemtoReg,
    output logic           RegDst,
    output logic           RegWrite,
    output logic           AluSrcA,
    output logic [1:0]     AluSrcB,
    output logic [1:0]     AluOp,
    output logic [1:0]     PCSource,
    output logic           halted,
    output logic           trap
);

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e          stateQ, stateD;
    logic [CntW-1:0] cntQ, cntD;
    logic            timedOut;
    ctrl_t           ctrl;

    // Zero only gates the PC in the datapath; the sequencer never branches on it.
    logic unusedZero;
    assign unusedZero = Zero;

    assign timedOut = (TIMEOUT != 0) && isWaitState(stateQ) && (cntQ == CntW'(TIMEOUT));

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            StInit:   stateD = StFetch;
            StFetch: begin
                if (timedOut) begin
                    stateD = StTrap;
                end else if (mem_ready) begin
                    stateD = StDecode;
                end
            end
            StDecode: begin
                case (Opcode)
                    OPW'(OP_R):                stateD = StExec;
                    OPW'(OP_LW), OPW'(OP_SW):  stateD = StMemAdr;
                    OPW'(OP_BEQ):              stateD = StBranch;
                    OPW'(OP_J):                stateD = StJump;
                    OPW'(OP_HALT):             stateD = StHalt;
                    default:                   stateD = StTrap;
                endcase
            end
            StMemAdr: stateD = (Opcode == OPW'(OP_LW)) ? StMemRd : StMemWr;
            StMemRd: begin
                if (timedOut) begin
                    stateD = StTrap;
                end else if (mem_ready) begin
                    stateD = StMemWb;
                end
            end
            StMemWb:  stateD = StFetch;
            StMemWr: begin
                if (timedOut) begin
                    stateD = StTrap;
                end else if (mem_ready) begin
                    stateD = StFetch;
                end
            end
            StExec:   stateD = StRwb;
            StRwb:    stateD = StFetch;
            StBranch: stateD = StFetch;
            StJump:   stateD = StFetch;
            StHalt:   stateD = StHalt;
            StTrap:   stateD = StTrap;
            default:  stateD = StTrap;
        endcase
    end

    // Clear on entering a wait state; count stalled cycles while waiting.
    always_comb begin
        cntD = cntQ;
        if (isWaitState(stateD) && (stateD != stateQ)) begin
            cntD = '0;
        end else if (isWaitState(stateQ) && !mem_ready) begin
            cntD = cntQ + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= StInit;
            cntQ   <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
        end
    end

    // A late mem_ready on the timeout cycle must not fire the fetch strobes.
    mc_ctrl_decode u_decode (
        .state    (stateQ),
        .memReady (mem_ready && !timedOut),
        .ctrl     (ctrl)
    );

    assign PCWrite     = ctrl.pcWrite;
    assign PCWriteCond = ctrl.pcWriteCond;
    assign IorD        = ctrl.iorD;
    assign MemRead     = ctrl.memRead;
    assign MemWrite    = ctrl.memWrite;
    assign IRWrite     = ctrl.irWrite;
    assign MemtoReg    = ctrl.memtoReg;
    assign RegDst      = ctrl.regDst;
    assign RegWrite    = ctrl.regWrite;
    assign AluSrcA     = ctrl.aluSrcA;
    assign AluSrcB     = ctrl.aluSrcB;
    assign AluOp       = ctrl.aluOp;
    assign PCSource    = ctrl.pcSource;
    assign halted      = ctrl.halted;
    assign trap        = ctrl.trap;

endmodule
